// File: rtl/redmule_tile_pkg.sv
// Shared types and defaults for the redmule_tile run-control sequencer.
package redmule_tile_pkg;

  localparam int unsigned CTRL_ENABLE_DLY = 4;
  localparam int unsigned CTRL_SLEEP_FILT = 8;

  typedef enum logic [2:0] {
    CTRL_IDLE,
    CTRL_EN_WAIT,
    CTRL_RUN,
    CTRL_WAKE,
    CTRL_DONE,
    CTRL_TIMEOUT
  } redmule_tile_ctrl_state_e;

  // Per-state output levels; loaded together with the state register so
  // every output comes straight from a flop.
  typedef struct packed {
    logic tile_en;
    logic fetch_en;
    logic wu_wfe;
    logic busy;
    logic done;
  } ctrl_outs_t;

  function automatic ctrl_outs_t ctrl_state_outs(input redmule_tile_ctrl_state_e s);
    ctrl_outs_t o;
    o = '0;
    case (s)
      CTRL_EN_WAIT: begin
        o.tile_en = 1'b1;
        o.busy    = 1'b1;
      end
      CTRL_RUN: begin
        o.tile_en  = 1'b1;
        o.fetch_en = 1'b1;
        o.busy     = 1'b1;
      end
      CTRL_WAKE: begin
        o.tile_en  = 1'b1;
        o.fetch_en = 1'b1;
        o.busy     = 1'b1;
        o.wu_wfe   = 1'b1;
      end
      CTRL_DONE: o.done = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/redmule_tile_ctrl_if.sv
// Control link between the run-control sequencer (master) and redmule_tile (slave).
interface redmule_tile_ctrl_if;
  logic        tile_enable;
  logic        fetch_enable;
  logic [31:0] boot_addr;
  logic [31:0] mhartid;
  logic        wu_wfe;
  logic        core_sleep;

  modport master (
    output tile_enable, fetch_enable, boot_addr, mhartid, wu_wfe,
    input  core_sleep
  );

  modport slave (
    input  tile_enable, fetch_enable, boot_addr, mhartid, wu_wfe,
    output core_sleep
  );
endinterface

// File: rtl/redmule_tile_ctrl_wdt.sv
// Saturating watchdog counter with clear, enable and limit compare.
module redmule_tile_ctrl_wdt #(
  parameter int unsigned WDT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WDT_W-1:0] limit_i,
  output logic             hit_o
);

  logic [WDT_W-1:0] cnt_q;

  // Clear loads 1: the accepting edge already opens the first busy cycle,
  // so the count equals the number of busy cycles including the current one.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= WDT_W'(1);
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + WDT_W'(1);
    end
  end

  assign hit_o = (limit_i != '0) && (cnt_q == limit_i);

endmodule

// File: rtl/redmule_tile_ctrl.sv
// Run-control sequencer for redmule_tile: start -> enable -> fetch -> run -> done,
// with counted wake-up events and an optional watchdog.
// Build option: REDMULE_TILE_CTRL_WDT_EN builds the watchdog and TIMEOUT state.
module redmule_tile_ctrl
  import redmule_tile_pkg::*;
#(
  parameter int unsigned ENABLE_DLY = CTRL_ENABLE_DLY,
  parameter int unsigned SLEEP_FILT = CTRL_SLEEP_FILT,
  parameter int unsigned EVT_CNT_W  = 4,
  parameter int unsigned WDT_W      = 32,
  parameter logic [31:0] HARTID     = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [31:0]          boot_addr_i,
  input  logic [WDT_W-1:0]     wdt_limit_i,
  input  logic                 evt_i,
  redmule_tile_ctrl_if.master  tile,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 timeout_o,
  output logic [EVT_CNT_W-1:0] evt_pending_o
);

  localparam int unsigned DLY_W  = (ENABLE_DLY > 1) ? $clog2(ENABLE_DLY) : 1;
  localparam int unsigned FILT_W = (SLEEP_FILT > 1) ? $clog2(SLEEP_FILT) : 1;

  redmule_tile_ctrl_state_e state_q;
  ctrl_outs_t               outs_q;
  logic [31:0]              boot_addr_q;
  logic [DLY_W-1:0]         dly_q;
  logic [FILT_W-1:0]        filt_q;
  logic [EVT_CNT_W-1:0]     evt_q;
  logic                     start_ok;
  logic                     wdt_hit;

  assign start_ok = start_i && (state_q inside {CTRL_IDLE, CTRL_DONE, CTRL_TIMEOUT});

`ifdef REDMULE_TILE_CTRL_WDT_EN
  logic timeout_q;

  redmule_tile_ctrl_wdt #(
    .WDT_W (WDT_W)
  ) u_wdt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (start_ok),
    .en_i    (outs_q.busy),
    .limit_i (wdt_limit_i),
    .hit_o   (wdt_hit)
  );

  // Timeout flag: set when the watchdog fires while busy, cleared by a new start.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timeout_q <= 1'b0;
    end else if (start_ok) begin
      timeout_q <= 1'b0;
    end else if (wdt_hit && outs_q.busy) begin
      timeout_q <= 1'b1;
    end
  end

  assign timeout_o = timeout_q;
`else
  logic wdt_limit_unused;
  assign wdt_limit_unused = ^wdt_limit_i;
  assign wdt_hit          = 1'b0;
  assign timeout_o        = 1'b0;
`endif

  // Sequencer FSM plus delay counter, sleep filter and event counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= CTRL_IDLE;
      outs_q      <= ctrl_state_outs(CTRL_IDLE);
      boot_addr_q <= '0;
      dly_q       <= '0;
      filt_q      <= '0;
      evt_q       <= '0;
    end else begin
      if (start_ok) begin
        evt_q <= '0;
      end else if (state_q == CTRL_WAKE) begin
        if (!evt_i) evt_q <= evt_q - EVT_CNT_W'(1);
      end else if (evt_i && (state_q != CTRL_IDLE) && (evt_q != '1)) begin
        evt_q <= evt_q + EVT_CNT_W'(1);
      end

      case (state_q)
        CTRL_IDLE, CTRL_DONE, CTRL_TIMEOUT: begin
          if (start_i) begin
            boot_addr_q <= boot_addr_i;
            dly_q       <= '0;
            filt_q      <= '0;
            state_q     <= CTRL_EN_WAIT;
            outs_q      <= ctrl_state_outs(CTRL_EN_WAIT);
          end
        end
        CTRL_EN_WAIT: begin
          if (wdt_hit) begin
            state_q <= CTRL_TIMEOUT;
            outs_q  <= ctrl_state_outs(CTRL_TIMEOUT);
          end else if (dly_q == DLY_W'(ENABLE_DLY - 1)) begin
            state_q <= CTRL_RUN;
            outs_q  <= ctrl_state_outs(CTRL_RUN);
          end else begin
            dly_q <= dly_q + DLY_W'(1);
          end
        end
        CTRL_RUN: begin
          if (wdt_hit) begin
            state_q <= CTRL_TIMEOUT;
            outs_q  <= ctrl_state_outs(CTRL_TIMEOUT);
          end else if (tile.core_sleep && (filt_q == FILT_W'(SLEEP_FILT - 1))) begin
            filt_q <= '0;
            if (evt_q != '0) begin
              state_q <= CTRL_WAKE;
              outs_q  <= ctrl_state_outs(CTRL_WAKE);
            end else begin
              state_q <= CTRL_DONE;
              outs_q  <= ctrl_state_outs(CTRL_DONE);
            end
          end else if (tile.core_sleep) begin
            filt_q <= filt_q + FILT_W'(1);
          end else begin
            filt_q <= '0;
          end
        end
        CTRL_WAKE: begin
          filt_q <= '0;
          if (wdt_hit) begin
            state_q <= CTRL_TIMEOUT;
            outs_q  <= ctrl_state_outs(CTRL_TIMEOUT);
          end else begin
            state_q <= CTRL_RUN;
            outs_q  <= ctrl_state_outs(CTRL_RUN);
          end
        end
        default: begin
          state_q <= CTRL_IDLE;
          outs_q  <= ctrl_state_outs(CTRL_IDLE);
        end
      endcase
    end
  end

  assign tile.tile_enable  = outs_q.tile_en;
  assign tile.fetch_enable = outs_q.fetch_en;
  assign tile.wu_wfe       = outs_q.wu_wfe;
  assign tile.boot_addr    = boot_addr_q;
  assign tile.mhartid      = HARTID;
  assign busy_o            = outs_q.busy;
  assign done_o            = outs_q.done;
  assign evt_pending_o     = evt_q;

endmodule

// File: tb/tb_redmule_tile_ctrl.sv
// Directed self-checking bench for redmule_tile_ctrl (default timing parameters).
module tb_redmule_tile_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] boot_addr_i;
  logic [31:0] wdt_limit_i;
  logic        evt_i;
  logic        busy_o;
  logic        done_o;
  logic        timeout_o;
  logic [3:0]  evt_pending_o;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  redmule_tile_ctrl_if tile_if ();

  redmule_tile_ctrl #(
    .ENABLE_DLY (4),
    .SLEEP_FILT (8),
    .EVT_CNT_W  (4),
    .WDT_W      (32),
    .HARTID     (32'h0000_0005)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .boot_addr_i   (boot_addr_i),
    .wdt_limit_i   (wdt_limit_i),
    .evt_i         (evt_i),
    .tile          (tile_if),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .timeout_o     (timeout_o),
    .evt_pending_o (evt_pending_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_ctl(input string tag, input logic te, input logic fe,
                           input logic bz, input logic dn);
    check({tag, "_tile_en"},  32'(tile_if.tile_enable),  32'(te));
    check({tag, "_fetch_en"}, 32'(tile_if.fetch_enable), 32'(fe));
    check({tag, "_busy"},     32'(busy_o),               32'(bz));
    check({tag, "_done"},     32'(done_o),               32'(dn));
  endtask

  task automatic check_reset(input string tag);
    check_ctl(tag, 1'b0, 1'b0, 1'b0, 1'b0);
    check({tag, "_wu"},      32'(tile_if.wu_wfe),   32'd0);
    check({tag, "_timeout"}, 32'(timeout_o),        32'd0);
    check({tag, "_boot"},    tile_if.boot_addr,     32'd0);
    check({tag, "_hartid"},  tile_if.mhartid,       32'h5);
    check({tag, "_evt"},     32'(evt_pending_o),    32'd0);
  endtask

  // Accept a start and advance to the first RUN cycle (t+5).
  task automatic start_run(input logic [31:0] addr);
    boot_addr_i = addr;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    #500000;
    $display("FAIL tb_time_limit: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n_wu;
    int w1;
    int w2;
    int d_at;
    int to_at;

    rst_i = 1'b1; start_i = 1'b0; boot_addr_i = '0; wdt_limit_i = '0; evt_i = 1'b0;
    tile_if.core_sleep = 1'b0;

    // Reset hold
    repeat (3) step();
    check_reset("reset");
    rst_i = 1'b0;
    step();

    // Start: enable at t+1, fetch at t+5
    boot_addr_i = 32'h1C00_0080;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    check_ctl("start_t1", 1'b1, 1'b0, 1'b1, 1'b0);
    check("start_boot", tile_if.boot_addr, 32'h1C00_0080);
    for (int k = 2; k <= 5; k++) begin
      step();
      check($sformatf("fetch_t%0d", k), 32'(tile_if.fetch_enable), 32'(k == 5));
    end

    // Clean finish: done visible after 8 sampled sleep cycles
    tile_if.core_sleep = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      check($sformatf("clean_done_%0d", i), 32'(done_o), 32'(i == 8));
    end
    tile_if.core_sleep = 1'b0;
    check_ctl("clean_end", 1'b0, 1'b0, 1'b0, 1'b1);
    check("clean_boot_hold", tile_if.boot_addr, 32'h1C00_0080);

    // Restart clears done, then two wake events
    boot_addr_i = 32'h1C00_00C0;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    check_ctl("restart", 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (4) step();
    evt_i = 1'b1; step(); evt_i = 1'b0; step();
    evt_i = 1'b1; step(); evt_i = 1'b0;
    check("evt_two", 32'(evt_pending_o), 32'd2);
    tile_if.core_sleep = 1'b1;
    n_wu = 0; w1 = 0; w2 = 0; d_at = 0;
    for (int i = 1; i <= 40 && d_at == 0; i++) begin
      step();
      if (tile_if.wu_wfe) begin
        n_wu++;
        if (n_wu == 1) w1 = i;
        else w2 = i;
      end
      if (done_o) d_at = i;
      if (i == 8)  check("evt_at_wake1", 32'(evt_pending_o), 32'd2);
      if (i == 9)  check("evt_after_wake1", 32'(evt_pending_o), 32'd1);
      if (i == 18) check("evt_after_wake2", 32'(evt_pending_o), 32'd0);
    end
    tile_if.core_sleep = 1'b0;
    check("wake_count", 32'(n_wu), 32'd2);
    check("wake1_cycle", 32'(w1), 32'd8);
    check("wake2_cycle", 32'(w2), 32'd17);
    check("wake_done_cycle", 32'(d_at), 32'd26);

    // Filter glitch: 7 high, 1 low, then 8 high
    start_run(32'h1C00_0080);
    tile_if.core_sleep = 1'b1;
    repeat (7) step();
    tile_if.core_sleep = 1'b0;
    step();
    check("glitch_no_done", 32'(done_o), 32'd0);
    tile_if.core_sleep = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      check($sformatf("glitch_done_%0d", i), 32'(done_o), 32'(i == 8));
    end
    tile_if.core_sleep = 1'b0;

    // Saturation: 20 events saturate at 15
    boot_addr_i = 32'h1C00_0100;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      evt_i = 1'b1; step(); evt_i = 1'b0; step();
    end
    check("evt_saturate", 32'(evt_pending_o), 32'd15);

    // Start while busy is ignored
    boot_addr_i = 32'hDEAD_0000;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    check("busy_start_boot", tile_if.boot_addr, 32'h1C00_0100);
    check("busy_start_evt", 32'(evt_pending_o), 32'd15);

    // Event coinciding with WAKE leaves count unchanged
    tile_if.core_sleep = 1'b1;
    repeat (8) step();
    check("sat_wake_pulse", 32'(tile_if.wu_wfe), 32'd1);
    evt_i = 1'b1;
    step();
    evt_i = 1'b0;
    check("sat_wake_evt_hold", 32'(evt_pending_o), 32'd15);
    check("sat_wake_single", 32'(tile_if.wu_wfe), 32'd0);
    repeat (8) step();
    check("sat_wake2_pulse", 32'(tile_if.wu_wfe), 32'd1);
    step();
    check("sat_wake2_dec", 32'(evt_pending_o), 32'd14);
    tile_if.core_sleep = 1'b0;

    // Reset mid-RUN
    rst_i = 1'b1;
    step();
    check_reset("mid_reset");
    rst_i = 1'b0;
    step();

    // Watchdog with limit 50 and no sleep
    wdt_limit_i = 32'd50;
    boot_addr_i = 32'h1C00_0200;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    to_at = 0;
    for (int i = 2; i <= 70 && to_at == 0; i++) begin
      step();
      if (timeout_o) to_at = i;
    end
`ifdef REDMULE_TILE_CTRL_WDT_EN
    check("wdt_timeout_cycle", 32'(to_at), 32'd51);
    check_ctl("wdt_end", 1'b0, 1'b0, 1'b0, 1'b0);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    check("wdt_restart_clear", 32'(timeout_o), 32'd0);
    check("wdt_restart_busy", 32'(busy_o), 32'd1);
`else
    check("nowdt_no_timeout", 32'(to_at), 32'd0);
    check("nowdt_still_busy", 32'(busy_o), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
